// File: rtl/sram_1rw_port_ctrl.sv
// Initiator-side controller for a 1RW SRAM macro port: registered command pins, fixed-edge
// read capture into a credit-protected response FIFO, optional post-reset zero-fill.
`timescale 1ns/1ps

module sram_1rw_port_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RSP_DEPTH  = 4,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned PtrW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned CredW = CntW + 1;
  localparam logic [ADDR_WIDTH:0] InitEnd = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH:0]   init_cnt_q;
  logic                  cmd_rd_q;
  logic                  inflight_rd_q;

  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PtrW-1:0]       wptr_q;
  logic [PtrW-1:0]       rptr_q;
  logic [CntW-1:0]       count_q;

  logic [CredW-1:0]      credit_used;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Every read in the command or capture stage already owns a FIFO slot, so a capture can
  // never find the FIFO full.
  always_comb begin
    credit_used = CredW'(count_q) + CredW'(cmd_rd_q) + CredW'(inflight_rd_q);
    req_ready   = init_done && (credit_used < CredW'(RSP_DEPTH));
  end

  assign accept    = req_valid && req_ready;
  assign push      = inflight_rd_q;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = rsp_valid ? fifo_mem[rptr_q] : '0;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q       <= INIT_CLEAR ? StInit : StRun;
      init_cnt_q    <= '0;
      init_done     <= 1'b0;
      csb0          <= 1'b1;
      web0          <= 1'b1;
      addr0         <= '0;
      din0          <= '0;
      cmd_rd_q      <= 1'b0;
      inflight_rd_q <= 1'b0;
    end else begin
      inflight_rd_q <= cmd_rd_q;
      cmd_rd_q      <= 1'b0;
      csb0          <= 1'b1;
      web0          <= 1'b1;
      unique case (state_q)
        StInit: begin
          if (init_cnt_q == InitEnd) begin
            state_q   <= StRun;
            init_done <= 1'b1;
          end else begin
            csb0       <= 1'b0;
            web0       <= 1'b0;
            addr0      <= init_cnt_q[ADDR_WIDTH-1:0];
            din0       <= '0;
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        StRun: begin
          init_done <= 1'b1;
          if (accept) begin
            csb0     <= 1'b0;
            web0     <= ~req_we;
            addr0    <= req_addr;
            cmd_rd_q <= ~req_we;
            if (req_we) din0 <= req_wdata;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // dout0 is only stable at this edge; it is captured here and nowhere else.
  always_ff @(posedge clk0) begin
    if (push) fifo_mem[wptr_q] <= dout0;
  end

endmodule

// File: tb/tb_sram_1rw_port_ctrl.sv
// Bench for sram_1rw_port_ctrl: behavioural 1RW macro, vector table plus scoreboard of reads,
// and directed sequences for init, latency, backpressure, async reset and INIT_CLEAR=0.
`timescale 1ns/1ps

module tb_sram_1rw_port_ctrl;

  logic        clk0 = 1'b0;
  logic        rst0 = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        init_done;
  logic        csb0;
  logic        web0;
  logic [9:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0 = '0;

  // Second instance with zero-fill disabled; only its reset behaviour is exercised.
  logic        rst_nc = 1'b1;
  logic        nc_req_ready, nc_rsp_valid, nc_init_done, nc_csb0, nc_web0;
  logic [31:0] nc_rsp_data, nc_din0;
  logic [9:0]  nc_addr0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  sram_1rw_port_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RSP_DEPTH(4), .INIT_CLEAR(1'b1)) dut (
    .clk0(clk0), .rst0(rst0), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .init_done(init_done), .csb0(csb0), .web0(web0), .addr0(addr0),
    .din0(din0), .dout0(dout0)
  );

  sram_1rw_port_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RSP_DEPTH(4), .INIT_CLEAR(1'b0)) dut_nc (
    .clk0(clk0), .rst0(rst_nc), .req_valid(1'b0), .req_ready(nc_req_ready), .req_we(1'b0),
    .req_addr(10'd0), .req_wdata(32'd0), .rsp_valid(nc_rsp_valid), .rsp_ready(1'b1),
    .rsp_data(nc_rsp_data), .init_done(nc_init_done), .csb0(nc_csb0), .web0(nc_web0),
    .addr0(nc_addr0), .din0(nc_din0), .dout0(32'd0)
  );

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc++;

  // Macro model: pins latched at posedge, write/read at negedge, output garbage after posedge.
  logic [31:0] sram [1024];
  logic        lat_csb = 1'b1, lat_web = 1'b1;
  logic [9:0]  lat_addr = '0;
  logic [31:0] lat_din = '0;
  always begin
    @(posedge clk0);
    lat_csb  = csb0;
    lat_web  = web0;
    lat_addr = addr0;
    lat_din  = din0;
    #1 dout0 = 32'hBAD0_BAD0;
    @(negedge clk0);
    if (!lat_csb) begin
      if (!lat_web) sram[lat_addr] = lat_din;
      else          dout0 = sram[lat_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response scoreboard: a pop happens at the next posedge when valid&ready here.
  always @(negedge clk0) begin
    if (!rst0 && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else                check("rsp_data", rsp_data, sb.pop_front());
    end
  end

  task automatic do_req(input logic we, input logic [9:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
    int   n = 0;
    logic acc = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!acc && n < 100) begin
      @(posedge clk0);
      n++;
      acc = req_ready;
    end
    if (acc) begin
      if (!we) sb.push_back(exp);
    end else begin
      check("req_accept_timeout", 32'd0, 32'd1);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk0);
      n++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    @(posedge clk0);
    #1;
  endtask

  task automatic init_check(input string tag);
    int   wr = 0, errs = 0, n = 0;
    logic last = 1'b0;
    while (!init_done && n < 2000) begin
      @(negedge clk0);
      n++;
      if (init_done) break;
      if (!csb0 && !web0 && addr0 == 10'(wr) && din0 == 32'd0) wr++;
      else errs++;
      last = !csb0 && (addr0 == 10'h3FF);
    end
    check({tag, "_init_writes"}, 32'(wr), 32'd1024);
    check({tag, "_init_seq_errs"}, 32'(errs), 32'd0);
    check({tag, "_done_after_last"}, 32'(last), 32'd1);
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
    check({tag, "_ready_after_init"}, 32'(req_ready), 32'd1);
    check({tag, "_csb_idle"}, 32'(csb0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int t0;
    for (int i = 0; i < 1024; i++) sram[i] = $urandom | 32'h1;

    vecs[0] = '{1'b0, 10'h005, 32'h0, 32'h0000_0000};
    vecs[1] = '{1'b1, 10'h3FF, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b0, 10'h3FF, 32'h0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 10'h010, 32'hA5A5_5A5A, 32'h0};
    vecs[4] = '{1'b0, 10'h010, 32'h0, 32'hA5A5_5A5A};
    vecs[5] = '{1'b0, 10'h000, 32'h0, 32'h0000_0000};
    vecs[6] = '{1'b1, 10'h000, 32'h1234_5678, 32'h0};
    vecs[7] = '{1'b0, 10'h000, 32'h0, 32'h1234_5678};
    for (int i = 0; i < 8; i++) vecs[8 + i] = '{1'b1, 10'(i + 1), 32'(i + 1), 32'h0};

    // Reset values, both instances held in reset.
    repeat (3) @(negedge clk0);
    check("rst_csb0", 32'(csb0), 32'd1);
    check("rst_web0", 32'(web0), 32'd1);
    check("rst_addr0", 32'(addr0), 32'd0);
    check("rst_din0", din0, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("nc_rst_req_ready", 32'(nc_req_ready), 32'd0);
    check("nc_rst_init_done", 32'(nc_init_done), 32'd0);

    // INIT_CLEAR=0: ready and done together on the first cycle after release.
    rst_nc = 1'b0;
    @(negedge clk0);
    check("nc_req_ready", 32'(nc_req_ready), 32'd1);
    check("nc_init_done", 32'(nc_init_done), 32'd1);
    check("nc_csb0_idle", 32'(nc_csb0), 32'd1);

    rst0 = 1'b0;
    init_check("boot");
    @(posedge clk0);
    #1;

    // Vector table, back to back, rsp_ready=1.
    for (int i = 0; i < 16; i++) do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    wait_drain("table");

    // Read latency and idle pin state.
    do_req(1'b0, 10'h3FF, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk0);
    check("lat_cmd_csb0", 32'(csb0), 32'd0);
    check("lat_cmd_web0", 32'(web0), 32'd1);
    check("lat_cmd_addr0", 32'(addr0), 32'h3FF);
    check("lat_p1_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk0);
    check("lat_p2_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk0);
    check("lat_p3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lat_p3_rsp_data", rsp_data, 32'hDEAD_BEEF);
    @(negedge clk0);
    check("idle_csb0", 32'(csb0), 32'd1);
    check("idle_web0", 32'(web0), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    wait_drain("latency");

    // Backpressure: only RSP_DEPTH reads accepted while the consumer stalls.
    rsp_ready = 1'b0;
    for (int a = 1; a <= 4; a++) do_req(1'b0, 10'(a), 32'h0, 32'(a));
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'd5;
    acc = 0;
    repeat (6) begin
      @(posedge clk0);
      if (req_ready) acc++;
    end
    @(negedge clk0);
    check("bp_extra_accepts", 32'(acc), 32'd0);
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_head", rsp_data, 32'd1);
    @(posedge clk0);
    #1 rsp_ready = 1'b1;
    for (int a = 5; a <= 8; a++) do_req(1'b0, 10'(a), 32'h0, 32'(a));
    wait_drain("backpressure");

    // Full-rate reads with a free-running consumer.
    t0 = cyc;
    for (int i = 0; i < 20; i++) do_req(1'b0, 10'((i % 8) + 1), 32'h0, 32'((i % 8) + 1));
    check("stream_cycles", 32'(cyc - t0), 32'd20);
    wait_drain("stream");

    // Asynchronous reset with reads in flight.
    rsp_ready = 1'b0;
    for (int a = 1; a <= 3; a++) do_req(1'b0, 10'(a), 32'h0, 32'(a));
    check("pre_rst_csb0", 32'(csb0), 32'd0);
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    #2 rst0 = 1'b1;
    #1;
    check("arst_csb0", 32'(csb0), 32'd1);
    check("arst_web0", 32'(web0), 32'd1);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_data", rsp_data, 32'd0);
    check("arst_init_done", 32'(init_done), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    @(posedge clk0);
    @(negedge clk0);
    rst0 = 1'b0;
    init_check("reinit");
    @(posedge clk0);
    #1 rsp_ready = 1'b1;
    do_req(1'b0, 10'h3FF, 32'h0, 32'h0);
    do_req(1'b0, 10'h001, 32'h0, 32'h0);
    wait_drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_1rw_port_ctrl.md
Name: sram_1rw_port_ctrl

Overview:
Initiator-side controller for a 1RW single-port SRAM macro port (csb0/web0/addr0/din0/dout0). It accepts word read/write requests on a valid/ready interface and drives the macro's active-low command pins from registers. It captures read data at the one legal sampling edge and returns it through a backpressured response FIFO. After reset it optionally zero-fills the whole array before accepting traffic.

Parameters:
DATA_WIDTH, 32, word width
ADDR_WIDTH, 10, address width; DEPTH = 1<<ADDR_WIDTH
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
INIT_CLEAR, 1, 1 = zero-fill all DEPTH words after reset

Ports:
clk0  in  1  clock; shared with the macro's clk0
rst0  in  1  asynchronous reset, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready at posedge
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read data valid (FIFO head)
rsp_ready  in  1  consumer pops head when valid&ready
rsp_data  out  DATA_WIDTH  read data, in request order
init_done  out  1  high once zero-fill is complete (or skipped)
csb0  out  1  to macro; active-low chip select
web0  out  1  to macro; active-low write enable
addr0  out  ADDR_WIDTH  to macro
din0  out  DATA_WIDTH  to macro
dout0  in  DATA_WIDTH  from macro

Behaviour:
- Reset values: csb0=1, web0=1, addr0=0, din0=0, req_ready=0, rsp_valid=0, rsp_data=0, init_done=0. FIFO is empty and the in-flight flags are cleared.
- FSM states: INIT, RUN.
  - After reset: INIT if INIT_CLEAR=1, else RUN.
  - INIT: issues a write every cycle to addr 0..DEPTH-1 with din0=0 (csb0=0, web0=0). On the cycle after the DEPTH-1 write is issued, go to RUN and set init_done=1.
  - req_ready=0 throughout INIT.
- Command stage: all macro pins are registered outputs. A request accepted at posedge P0 drives the pins during cycle P0..P1, and the macro latches them at P1.
- Idle cycles: csb0=1, web0=1; addr0/din0 hold their last values.
- Read pipeline:
  - cmd_rd (set at P0) shifts into inflight_rd at P1.
  - At P2, when inflight_rd=1, dout0 is pushed into the FIFO. P2 is the only legal sample; dout0 goes X shortly after each posedge.
  - rsp_valid is high from P2 onward. Read latency from acceptance to rsp_valid is 2 cycles.
- Credits:
  - req_ready = RUN && (fifo_count + cmd_rd + inflight_rd < RSP_DEPTH).
  - Writes are gated by the same term; this stall is intended.
  - Guarantee: a captured read never finds the FIFO full, and no data is ever dropped.
- Full-rate operation: back-to-back requests every cycle are supported while credits remain. A write followed by a read of the same address on the next cycle returns the new data, because the macro writes at negedge before the later read.
- FIFO:
  - Simultaneous push and pop in one cycle leaves fifo_count unchanged.
  - A pop on empty is impossible, since rsp_valid gates the pop.
  - Pointers wrap modulo RSP_DEPTH.
  - rsp_data presents the head combinationally from FIFO storage; the reset value is 0.
- Writes produce no response.
- Reset mid-operation:
  - Flushes the FIFO and in-flight reads, forces csb0=1 immediately (asynchronous), and restarts INIT.
  - Pending responses are lost and the requester must re-issue.

Test Plan:
- Reset, INIT_CLEAR=1 -> exactly 1024 cycles of csb0=0, web0=0, addr0=0..1023, din0=0; init_done=1 on the next cycle; then read addr 5 -> rsp_data=0x00000000 two cycles after acceptance.
- Write 0xDEADBEEF to 0x3FF, then read 0x3FF on the next cycle -> rsp_valid two cycles after read acceptance with rsp_data=0xDEADBEEF; csb0/web0 return to 1/1 when idle.
- rsp_ready=0 with continuous reads of addrs 1..8 (pre-written with value=addr) -> exactly 4 accepted, then req_ready=0. Raise rsp_ready -> data 1,2,3,4 then 5..8 in order, none lost.
- Full FIFO with rsp_ready=1 and req_valid=1 every cycle -> steady state push+pop each cycle, fifo_count constant, no overflow.
- Assert rst0 asynchronously mid-clock while 2 reads are in flight -> csb0=1 immediately, rsp_valid=0, init_done=0, INIT restarts from addr 0.
- INIT_CLEAR=0 -> req_ready=1 on the first cycle after reset release; init_done=1 at the same time.
